fir_filter: RTL and testbench

//   N-tap direct-form FIR filter with fixed integer coefficients h[k]=k+1 (k=0..N-1).
//   - Consumes one signed sample per clock.
//   - Produces one registered signed output per clock.
//   - Sits in the sample-rate datapath. No handshake; every clock edge is a valid sample.

---
 rtl/fir_filter.sv | 115 +++++++++++
 tb/tb_fir_filter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter.sv
`default_nettype none
// ============================================================================
//  Module   : fir_filter
//  Purpose  : N-tap direct-form FIR filter with fixed coefficients
//             h[k] = k+1.  Tap 0 weights the newest sample.  It accepts one
//             signed sample per clock and produces one registered signed
//             output per clock, with one clock of latency.
//  Ports    : clk    - rising-edge clock
//             rst    - synchronous reset, active-high; clears history/output
//             x_in   - signed input sample, DATA_WIDTH bits
//             y_out  - signed registered output, 2*DATA_WIDTH bits
//  Params   : N (taps, 1..2**(DATA_WIDTH-1)-1), DATA_WIDTH (sample width)
//  Options  : FIR_SATURATE_EN - when defined, the full-precision sum is
//             clamped to the output range.  When it is undefined, the sum
//             wraps (two's complement) to the output range.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_filter #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  x_in,
    output logic signed [2*DATA_WIDTH-1:0] y_out
);

    localparam int c_OUT_W = 2 * DATA_WIDTH;
    localparam int c_ACC_W = 2 * DATA_WIDTH + $clog2(N) + 1;

    // Sign-extend a sample to accumulator width. Every product and partial
    // sum is formed at this width, so nothing is truncated before the
    // final output reduction.
    function automatic logic signed [c_ACC_W-1:0] sext(
        input logic signed [DATA_WIDTH-1:0] v
    );
        return {{(c_ACC_W-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    logic signed [c_ACC_W-1:0] w_tap_sum;  // taps 1..N-1 (delayed samples)
    logic signed [c_ACC_W-1:0] w_sum;      // full-precision S
    logic signed [c_OUT_W-1:0] w_y_d;
    logic signed [c_OUT_W-1:0] r_y_q;

    // -------------------------------------------------------------------
    // Delay line and delayed-tap sum. The delay line exists only when
    // N > 1. A single-tap filter is a registered pass-through of x_in.
    // -------------------------------------------------------------------
    generate
        if (N > 1) begin : g_delay
            logic signed [DATA_WIDTH-1:0] r_dly_q [N-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < N - 1; k++) begin
                        r_dly_q[k] <= '0;
                    end
                end else begin
                    r_dly_q[0] <= x_in;
                    for (int k = 1; k < N - 1; k++) begin
                        r_dly_q[k] <= r_dly_q[k-1];
                    end
                end
            end

            // d[k-1] is weighted by h[k] = k+1.
            always_comb begin
                w_tap_sum = '0;
                for (int k = 1; k < N; k++) begin
                    w_tap_sum = w_tap_sum
                              + $signed(c_ACC_W'(k + 1)) * sext(r_dly_q[k-1]);
                end
            end
        end else begin : g_no_delay
            assign w_tap_sum = '0;
        end
    endgenerate

    // h[0] = 1, so the newest sample enters the sum unscaled.
    assign w_sum = sext(x_in) + w_tap_sum;

    // -------------------------------------------------------------------
    // Output width reduction
    // -------------------------------------------------------------------
`ifdef FIR_SATURATE_EN
    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX =
        {{(c_ACC_W-c_OUT_W+1){1'b0}}, {(c_OUT_W-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN =
        {{(c_ACC_W-c_OUT_W+1){1'b1}}, {(c_OUT_W-1){1'b0}}};

    always_comb begin
        w_y_d = w_sum[c_OUT_W-1:0];
        if (w_sum > c_SAT_MAX) begin
            w_y_d = c_SAT_MAX[c_OUT_W-1:0];
        end else if (w_sum < c_SAT_MIN) begin
            w_y_d = c_SAT_MIN[c_OUT_W-1:0];
        end
    end
`else
    // Two's-complement wrap: keep the low output bits of S.
    assign w_y_d = w_sum[c_OUT_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q <= '0;
        end else begin
            r_y_q <= w_y_d;
        end
    end

    assign y_out = r_y_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_filter
//  Purpose  : Self-checking bench for fir_filter. It uses a default
//             instance (N=4, DATA_WIDTH=8) and an overflow instance
//             (N=6, DATA_WIDTH=4). Hand-computed vector tables, overflow
//             sequences and random stimulus are checked against a
//             history-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_filter;

    localparam int c_N1 = 4;
    localparam int c_W1 = 8;
    localparam int c_N2 = 6;
    localparam int c_W2 = 4;

    logic                    clk = 1'b0;
    logic                    rst1 = 1'b1;
    logic                    rst2 = 1'b1;
    logic signed [c_W1-1:0]  x1 = '0;
    logic signed [c_W2-1:0]  x2 = '0;
    logic signed [2*c_W1-1:0] y1;
    logic signed [2*c_W2-1:0] y2;

    fir_filter #(.N(c_N1), .DATA_WIDTH(c_W1)) u_dut1 (
        .clk   (clk),
        .rst   (rst1),
        .x_in  (x1),
        .y_out (y1)
    );

    fir_filter #(.N(c_N2), .DATA_WIDTH(c_W2)) u_dut2 (
        .clk   (clk),
        .rst   (rst2),
        .x_in  (x2),
        .y_out (y2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: input history since the last reset, newest first
    int hist1 [c_N1];
    int hist2 [c_N2];
    int exp1 = 0;
    int exp2 = 0;

    // Reduce a full-precision sum to an ow-bit signed output
    function automatic int reduce(input int s, input int ow);
        int hi;
        int lo;
        int m;
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        m  = s;
`ifdef FIR_SATURATE_EN
        if (s > hi) m = hi;
        if (s < lo) m = lo;
`else
        m = s & ((1 << ow) - 1);
        if (m > hi) m = m - (1 << ow);
`endif
        return m;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Drive both DUTs for one edge, then advance the reference model
    task automatic tick(input bit r1, input int v1, input bit r2, input int v2);
        int s;
        rst1 = r1;
        x1   = c_W1'(v1);
        rst2 = r2;
        x2   = c_W2'(v2);
        @(posedge clk);
        #1;
        if (r1) begin
            for (int k = 0; k < c_N1; k++) hist1[k] = 0;
        end else begin
            for (int k = c_N1 - 1; k > 0; k--) hist1[k] = hist1[k-1];
            hist1[0] = v1;
        end
        s = 0;
        if (!r1) for (int k = 0; k < c_N1; k++) s += (k + 1) * hist1[k];
        exp1 = reduce(s, 2 * c_W1);
        if (r2) begin
            for (int k = 0; k < c_N2; k++) hist2[k] = 0;
        end else begin
            for (int k = c_N2 - 1; k > 0; k--) hist2[k] = hist2[k-1];
            hist2[0] = v2;
        end
        s = 0;
        if (!r2) for (int k = 0; k < c_N2; k++) s += (k + 1) * hist2[k];
        exp2 = reduce(s, 2 * c_W2);
    endtask

    typedef struct {
        bit    rst;
        int    x;
        int    y;
        string tag;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input int x, input int y, input string tag);
        vec_t v;
        v.rst = r;
        v.x   = x;
        v.y   = y;
        v.tag = tag;
        tbl.push_back(v);
    endfunction

    initial begin
        int ovf_pos [6];
        int r_x1;
        int r_x2;
        bit r_r1;
        bit r_r2;

        // ---- default-instance vectors, expected values computed by hand ----
        add(1, 55, 0, "reset0");
        add(1, 55, 0, "reset1");
        add(0, 0, 0, "post_reset_zero");
        add(0, 1, 1, "impulse0");
        add(0, 0, 2, "impulse1");
        add(0, 0, 3, "impulse2");
        add(0, 0, 4, "impulse3");
        add(0, 0, 0, "impulse4");
        add(0, 10, 10, "step0");
        add(0, 10, 30, "step1");
        add(0, 10, 60, "step2");
        add(0, 10, 100, "step3");
        add(0, 10, 100, "step4");
        add(1, 0, 0, "ramp_rst");
        add(0, 0, 0, "ramp0");
        add(0, 1, 1, "ramp1");
        add(0, 2, 4, "ramp2");
        add(0, 3, 10, "ramp3");
        add(0, 4, 20, "ramp4");
        add(1, 0, 0, "alt_rst");
        add(0, 20, 20, "alt0");
        add(0, -20, 20, "alt1");
        add(0, 20, 40, "alt2");
        add(0, -20, 40, "alt_neg");
        add(0, 20, -40, "alt_pos");
        add(0, -20, 40, "alt_neg2");
        add(0, 0, -60, "drain0");
        add(0, 0, 20, "drain1");
        add(0, 0, -80, "drain2");
        add(0, 0, 0, "drain3");
        add(0, 0, 0, "drain_hold");
        add(0, 10, 10, "mid_step0");
        add(0, 10, 30, "mid_step1");
        add(0, 10, 60, "mid_step2");
        add(1, 10, 0, "mid_reset");
        add(0, 10, 10, "mid_after0");
        add(0, 10, 30, "mid_after1");
        add(0, 10, 60, "mid_after2");
        add(0, 10, 100, "mid_after3");
        add(1, 0, 0, "min_rst");
        add(0, -128, -128, "min0");
        add(0, -128, -384, "min1");
        add(0, -128, -768, "min2");
        add(0, -128, -1280, "min3");
        add(0, 127, -1025, "max0");
        add(0, 127, -515, "max1");
        add(0, 127, 250, "max2");
        add(0, 127, 1270, "max3");

        // The overflow instance is held in reset during the table
        foreach (tbl[i]) begin
            tick(tbl[i].rst, tbl[i].x, 1'b1, 0);
            check(tbl[i].tag, int'(y1), tbl[i].y);
        end
        check("ovf_idle_reset", int'(y2), 0);

        // ---- overflow instance: constant +7 builds S=147 ----
        ovf_pos = '{7, 21, 42, 70, 105, 0};
`ifdef FIR_SATURATE_EN
        ovf_pos[5] = 127;
`else
        ovf_pos[5] = -109;
`endif
        tick(1'b1, 0, 1'b1, 0);
        check("ovf_reset", int'(y2), 0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 0, 1'b0, 7);
            check($sformatf("ovf_pos%0d", i), int'(y2), ovf_pos[i]);
        end
        // constant -8 until the window holds only -8: S=-168
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 0, 1'b0, -8);
            check($sformatf("ovf_mix%0d", i), int'(y2), exp2);
        end
        tick(1'b1, 0, 1'b0, -8);
`ifdef FIR_SATURATE_EN
        check("ovf_neg", int'(y2), -128);
`else
        check("ovf_neg", int'(y2), 88);
`endif

        // ---- randomized stimulus against the reference model ----
        tick(1'b1, 0, 1'b1, 0);
        for (int i = 0; i < 400; i++) begin
            r_r1 = ($urandom_range(31) == 0);
            r_r2 = ($urandom_range(31) == 0);
            r_x1 = int'($urandom_range(254)) - 127;
            r_x2 = int'($urandom_range(15)) - 8;
            tick(r_r1, r_x1, r_r2, r_x2);
            check("rand_n4w8", int'(y1), exp1);
            check("rand_n6w4", int'(y2), exp2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
